// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch predictor.
// The master is the pipeline; the slave is the predictor.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped conditional-branch predictor: 2-bit counters plus cached targets,
// trained from execute, producing a registered flush/redirect on mispredicts.
module branch_predictor #(
  parameter int IDX_BITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 30 - IDX_BITS;

  logic                r_valid  [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [31:0]         r_target [ENTRIES];

  logic        r_mispredict;
  logic [31:0] r_redirect_pc;
  logic [31:0] r_branch_count;
  logic [31:0] r_mispredict_count;

  logic [IDX_BITS-1:0] w_f_idx;
  logic [TAG_BITS-1:0] w_f_tag;
  logic                w_f_hit;
  logic                w_f_taken;
  logic [IDX_BITS-1:0] w_u_idx;
  logic [TAG_BITS-1:0] w_u_tag;
  logic                w_u_hit;
  logic                w_mis;

  assign w_f_idx = bp.fetch_pc[IDX_BITS+1:2];
  assign w_f_tag = bp.fetch_pc[31:IDX_BITS+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  // Gating with reset keeps fetch sequential while the table is being cleared.
  assign w_f_taken      = !reset && w_f_hit && r_ctr[w_f_idx][1];
  assign bp.pred_taken  = w_f_taken;
  assign bp.pred_target = w_f_taken ? r_target[w_f_idx] : bp.fetch_pc + 32'd4;

  assign w_u_idx = bp.upd_pc[IDX_BITS+1:2];
  assign w_u_tag = bp.upd_pc[31:IDX_BITS+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  assign w_mis = bp.upd_valid &&
                 ((bp.upd_taken != bp.upd_pred_taken) ||
                  (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));

  // NOTE: state is assigned with <= so every reader in this edge sees pre-update values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (bp.upd_valid) begin
      if (w_u_hit) begin
        if (bp.upd_taken) begin
          if (r_ctr[w_u_idx] != 2'b11) r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
        end else begin
          if (r_ctr[w_u_idx] != 2'b00) r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
        end
      end else if (bp.upd_taken) begin
        r_valid[w_u_idx] <= 1'b1;
        r_ctr[w_u_idx]   <= 2'b10;
      end
    end
  end

  // NOTE: tag/target arrays are not reset; the cleared valid bits make their contents don't-care.
  always_ff @(posedge clk) begin
    if (!reset && bp.upd_valid && bp.upd_taken) begin
      r_target[w_u_idx] <= bp.upd_target;
      if (!w_u_hit) r_tag[w_u_idx] <= w_u_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mispredict       <= 1'b0;
      r_redirect_pc      <= 32'd0;
      r_branch_count     <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      r_mispredict <= w_mis;
      if (w_mis) begin
        r_redirect_pc <= bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;
        if (r_mispredict_count != 32'hFFFF_FFFF)
          r_mispredict_count <= r_mispredict_count + 32'd1;
      end
      if (bp.upd_valid && (r_branch_count != 32'hFFFF_FFFF))
        r_branch_count <= r_branch_count + 32'd1;
    end
  end

  assign bp.mispredict       = r_mispredict;
  assign bp.redirect_pc      = r_redirect_pc;
  assign bp.branch_count     = r_branch_count;
  assign bp.mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against an array-based reference model of the predictor.
module tb_branch_predictor;
  localparam int IDX_BITS = 6;
  localparam int ENTRIES  = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays, counter as an integer 0..3.
  bit          m_valid  [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  bit          m_mis;
  logic [31:0] m_redir;
  logic [31:0] m_bcount;
  logic [31:0] m_mcount;
  bit          chk_en = 1'b0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_BITS + 2);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit model_taken(input logic [31:0] pc);
    return model_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_taken(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic model_update();
    int          i;
    bit          hit;
    bit          m;
    logic [31:0] pc;
    pc = bp_if.upd_pc;
    if (reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
      m_mis = 1'b0; m_redir = '0; m_bcount = '0; m_mcount = '0;
    end else if (bp_if.upd_valid) begin
      i   = idx_of(pc);
      hit = model_hit(pc);
      m   = (bp_if.upd_taken != bp_if.upd_pred_taken) ||
            (bp_if.upd_taken && (bp_if.upd_target != bp_if.upd_pred_target));
      if (m_bcount != 32'hFFFF_FFFF) m_bcount = m_bcount + 1;
      if (m) begin
        if (m_mcount != 32'hFFFF_FFFF) m_mcount = m_mcount + 1;
        m_redir = bp_if.upd_taken ? bp_if.upd_target : pc + 32'd4;
      end
      m_mis = m;
      if (hit) begin
        if (bp_if.upd_taken) begin
          m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = bp_if.upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (bp_if.upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(pc);
        m_target[i] = bp_if.upd_target;
        m_ctr[i]    = 2;
      end
    end else begin
      m_mis = 1'b0;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    bit          exp_t;
    logic [31:0] exp_tgt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_t   = !reset && model_taken(bp_if.fetch_pc);
        exp_tgt = exp_t ? m_target[idx_of(bp_if.fetch_pc)] : bp_if.fetch_pc + 32'd4;
        check("pred_taken",       32'(bp_if.pred_taken), 32'(exp_t));
        check("pred_target",      bp_if.pred_target,      exp_tgt);
        check("mispredict",       32'(bp_if.mispredict),  32'(m_mis));
        check("redirect_pc",      bp_if.redirect_pc,      m_redir);
        check("branch_count",     bp_if.branch_count,     m_bcount);
        check("mispredict_count", bp_if.mispredict_count, m_mcount);
      end
    end
  end

  task automatic apply(input logic [31:0] fpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
    bp_if.fetch_pc        = fpc;
    bp_if.upd_valid       = uv;
    bp_if.upd_pc          = upc;
    bp_if.upd_taken       = ut;
    bp_if.upd_target      = utgt;
    bp_if.upd_pred_taken  = upt;
    bp_if.upd_pred_target = uptgt;
  endtask

  task automatic idle(input logic [31:0] fpc);
    apply(fpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    chk_en = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] upc, utgt, fpc;
    bit          ut, upt;
    logic [31:0] uptgt;

    reset = 1'b1;
    idle(32'h100);
    tick(); tick();
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst pred_taken",  32'(bp_if.pred_taken), 32'd0);
    check("rst pred_target", bp_if.pred_target, 32'h104);
    check("rst bcount",      bp_if.branch_count, 32'd0);
    check("rst mcount",      bp_if.mispredict_count, 32'd0);
    check("rst mispredict",  32'(bp_if.mispredict), 32'd0);
    tick();

    // First taken branch allocates and mispredicts.
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    idle(32'h100);
    @(negedge clk);
    check("alloc mispredict",  32'(bp_if.mispredict), 32'd1);
    check("alloc redirect",    bp_if.redirect_pc, 32'h40);
    check("alloc pred_taken",  32'(bp_if.pred_taken), 32'd1);
    check("alloc pred_target", bp_if.pred_target, 32'h40);
    check("alloc bcount",      bp_if.branch_count, 32'd1);
    check("alloc mcount",      bp_if.mispredict_count, 32'd1);
    tick();
    @(negedge clk);
    check("pulse one cycle", 32'(bp_if.mispredict), 32'd0);

    // Not-taken: ctr 10 -> 01.
    apply(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    tick();
    idle(32'h100);
    @(negedge clk);
    check("nt mispredict", 32'(bp_if.mispredict), 32'd1);
    check("nt redirect",   bp_if.redirect_pc, 32'h104);
    check("nt pred_taken", 32'(bp_if.pred_taken), 32'd0);
    tick();

    // Taken x3 (01->10->11->11) then not-taken (11->10).
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104); tick();
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);  tick();
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);  tick();
    apply(32'h100, 1'b1, 32'h100, 1'b0, 32'h0,  1'b1, 32'h40);  tick();
    idle(32'h100);
    @(negedge clk);
    check("sat pred_taken", 32'(bp_if.pred_taken), 32'd1);
    check("sat bcount",     bp_if.branch_count, 32'd6);
    check("sat mcount",     bp_if.mispredict_count, 32'd4);
    tick();

    // Aliasing at idx 0: 0x200 misses, then evicts 0x100.
    idle(32'h200);
    @(negedge clk);
    check("alias pred_taken",  32'(bp_if.pred_taken), 32'd0);
    check("alias pred_target", bp_if.pred_target, 32'h204);
    apply(32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    tick();
    idle(32'h100);
    @(negedge clk);
    check("evicted pred_taken",  32'(bp_if.pred_taken), 32'd0);
    check("evicted pred_target", bp_if.pred_target, 32'h104);
    tick();
    idle(32'h200);
    @(negedge clk);
    check("new owner target", bp_if.pred_target, 32'h300);
    tick();

    // Same-cycle fetch and update: old prediction visible, trained next cycle.
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104); tick();
    apply(32'h100, 1'b1, 32'h100, 1'b0, 32'h0,  1'b1, 32'h40);
    @(negedge clk);
    check("same-cycle old", 32'(bp_if.pred_taken), 32'd1);
    tick();
    idle(32'h100);
    @(negedge clk);
    check("same-cycle trained", 32'(bp_if.pred_taken), 32'd0);
    tick();

    // Correct prediction: no pulse.
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104); tick();
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);  tick();
    idle(32'h100);
    @(negedge clk);
    check("correct no pulse", 32'(bp_if.mispredict), 32'd0);
    tick();

    // Reset mid-stream with an offending update present.
    reset = 1'b1;
    apply(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    @(negedge clk);
    check("in-reset pred_taken",  32'(bp_if.pred_taken), 32'd0);
    check("in-reset pred_target", bp_if.pred_target, 32'h104);
    tick();
    reset = 1'b0;
    idle(32'h100);
    @(negedge clk);
    check("post-rst mispredict", 32'(bp_if.mispredict), 32'd0);
    check("post-rst bcount",     bp_if.branch_count, 32'd0);
    check("post-rst pred_taken", 32'(bp_if.pred_taken), 32'd0);
    tick();

    // Random traffic over a small PC pool to force hits and aliases.
    for (int n = 0; n < 3000; n++) begin
      fpc  = ($urandom_range(3) << 8) | ($urandom_range(7) << 2) | $urandom_range(3);
      upc  = ($urandom_range(3) << 8) | ($urandom_range(7) << 2) | $urandom_range(3);
      ut   = ($urandom_range(99) < 60);
      case ($urandom_range(3))
        0: utgt = 32'h40;
        1: utgt = 32'h80;
        2: utgt = 32'hFFFF_FFFC;
        default: utgt = $urandom;
      endcase
      if ($urandom_range(3) != 0) begin
        upt   = model_taken(upc);
        uptgt = model_target(upc);
      end else begin
        upt   = $urandom_range(1);
        uptgt = ($urandom_range(1) == 1) ? utgt : upc + 32'd4;
      end
      reset = ($urandom_range(299) == 0);
      apply(fpc, ($urandom_range(99) < 60), upc, ut, utgt, upt, uptgt);
      tick();
    end
    reset = 1'b0;
    idle(32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the execute-stage branch resolution logic.
- Predicts at fetch whether a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU) will be taken, and its target, using a direct-mapped table. Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter.
- Execute returns the resolved outcome (branch-taken select plus computed target). The block then trains the table, flags mispredictions and supplies the fetch redirect PC.

Parameters:
- IDX_BITS, 6, table index width; ENTRIES = 2**IDX_BITS (64).
- Derived: TAG_BITS = 30 - IDX_BITS. Not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_pc  in  32  PC of the instruction being fetched.
- pred_taken  out  1  prediction for fetch_pc; combinational from table state.
- pred_target  out  32  predicted next PC; combinational.
- upd_valid  in  1  execute stage resolved a conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved outcome (branch-taken select).
- upd_target  in  32  resolved branch target (PC + B-immediate).
- upd_pred_taken  in  1  pred_taken value piped down with the branch.
- upd_pred_target  in  32  pred_target value piped down with the branch.
- mispredict  out  1  registered one-cycle pulse: fetch must flush and redirect.
- redirect_pc  out  32  registered correct next PC; valid while mispredict=1.
- branch_count  out  32  resolved-branch counter, saturating.
- mispredict_count  out  32  misprediction counter, saturating.

Behaviour:
Indexing:
- idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]; pc[1:0] ignored.
- hit = valid[idx] && tag[idx] == tag(pc).

Prediction (combinational, zero latency):
- pred_taken = hit && ctr[idx][1].
- pred_target = pred_taken ? target[idx] : fetch_pc + 4. Addition is 32-bit and wraps modulo 2^32.

Training (registered, takes effect on the rising edge after upd_valid=1):
- Hit, upd_taken=1: ctr increments, saturating at 2'b11; target <= upd_target.
- Hit, upd_taken=0: ctr decrements, saturating at 2'b00; target unchanged.
- Miss, upd_taken=1: allocate the entry (overwrite any alias): valid=1, tag=tag(upd_pc), target=upd_target, ctr=2'b10.
- Miss, upd_taken=0: no table change.
- upd_valid=0: no table, counter or statistics change.

Misprediction:
- Condition: m = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- Next cycle: mispredict <= m.
- redirect_pc <= upd_taken ? upd_target : upd_pc + 4. Loaded only when m=1, otherwise held.
- mispredict is a single-cycle pulse per offending update. Back-to-back updates can produce back-to-back pulses.

Statistics:
- branch_count +1 on every upd_valid.
- mispredict_count +1 on every m.
- Both hold at 32'hFFFF_FFFF; no wrap.

Simultaneous events:
- Fetch and update to the same idx in one cycle: the prediction uses the pre-update table state. No bypass.

Reset:
- Sync, highest priority, legal mid-operation.
- Clears all valid bits and sets all ctr to 2'b01. Tag and target storage need no reset.
- mispredict=0, redirect_pc=0, branch_count=0, mispredict_count=0.
- Any update presented in the reset cycle is discarded.
- During and after reset, pred_taken=0 and pred_target=fetch_pc+4.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; both counts 0; mispredict=0.
- Update pc=0x100, taken=1, target=0x40, pred_taken=0 -> next cycle mispredict=1 and redirect_pc=0x40 for exactly one cycle; fetch 0x100 then gives pred_taken=1, pred_target=0x40; branch_count=1, mispredict_count=1.
- Counter training on pc=0x100, starting from ctr=2'b10:
  - Not-taken update (pred_taken=1) -> mispredict pulse, redirect_pc=0x104; ctr=01; fetch 0x100 gives pred_taken=0.
  - Two taken updates -> ctr 10 then 11.
  - A third taken update -> stays 11.
  - One not-taken update -> 10, and pred_taken stays 1.
- Aliasing: allocate 0x100, then fetch 0x200 (same idx, different tag) -> pred_taken=0, pred_target=0x204. Taken update at 0x200 with target 0x300 evicts the entry, so fetch 0x100 now misses.
- Same-cycle fetch and update of 0x100 -> that cycle shows the old prediction; the following cycle shows the trained value.
- Correct prediction (taken, target match) -> no mispredict pulse, branch_count+1 only. Assert reset mid-stream with upd_valid=1 -> update discarded, table and counts cleared, no pulse afterward.
